// File: rtl/i2c_lcd_backpack_target.sv
// I2C target emulating a PCF8574-style LCD backpack: written bytes drive port_out,
// reads return a snapshot of port_in. SDA is pulled low through sda_oe only.
module i2c_lcd_backpack_target #(
    parameter logic [6:0] ADDR      = 7'h27,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] port_out,
    output logic       byte_stb,
    input  logic [7:0] port_in,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR,
        S_WR_ACK,
        S_RD,
        S_RD_ACK,
        S_IGNORE
    } state_t;

    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       phase_q, phase_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic [7:0] port_q, port_d;
    logic       stb_q, stb_d;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    // Synchronizers reset low so a reset released mid-bus never fakes a START/STOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta_q <= 1'b0;
            scl_sync_q <= 1'b0;
            scl_prev_q <= 1'b0;
            sda_meta_q <= 1'b0;
            sda_sync_q <= 1'b0;
            sda_prev_q <= 1'b0;
        end else begin
            scl_meta_q <= scl_i;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    assign scl_rise  = scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q & scl_prev_q;
    assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
    assign rx_byte   = {shift_q[6:0], sda_sync_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        rw_d    = rw_q;
        phase_d = phase_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        port_d  = port_q;
        stb_d   = 1'b0;

        if (start_det) begin
            state_d = S_ADDR;
            cnt_d   = 3'd0;
            shift_d = 8'h00;
            phase_d = 1'b0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (stop_det) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
            shift_d = 8'h00;
            phase_d = 1'b0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    oe_d = 1'b0;
                end
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            // General call (address 0) is never acknowledged.
                            if (rx_byte[7:1] == ADDR && rx_byte[7:1] != 7'd0) begin
                                state_d = S_ADDR_ACK;
                                rw_d    = rx_byte[0];
                                phase_d = 1'b0;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            oe_d    = 1'b1;
                            busy_d  = 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            cnt_d   = 3'd0;
                            if (rw_q) begin
                                state_d = S_RD;
                                shift_d = port_in;
                                oe_d    = ~port_in[7];
                            end else begin
                                state_d = S_WR;
                                oe_d    = 1'b0;
                            end
                        end
                    end
                end
                S_WR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_d = S_WR_ACK;
                            phase_d = 1'b0;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            oe_d    = 1'b1;
                            port_d  = shift_q;
                            stb_d   = 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            phase_d = 1'b0;
                            cnt_d   = 3'd0;
                            state_d = S_WR;
                        end
                    end
                end
                S_RD: begin
                    // Bits advance on SCL fall; the shift register holds the remaining bits.
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            oe_d    = 1'b0;
                            state_d = S_RD_ACK;
                            phase_d = 1'b0;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                            cnt_d   = cnt_q + 3'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_sync_q) begin
                            phase_d = 1'b1;
                        end else begin
                            state_d = S_IGNORE;
                            oe_d    = 1'b0;
                        end
                    end else if (scl_fall && phase_q) begin
                        state_d = S_RD;
                        shift_d = port_in;
                        oe_d    = ~port_in[7];
                        cnt_d   = 3'd0;
                        phase_d = 1'b0;
                    end
                end
                S_IGNORE: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            shift_q <= 8'h00;
            rw_q    <= 1'b0;
            phase_q <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            port_q  <= RESET_VAL;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            rw_q    <= rw_d;
            phase_q <= phase_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            port_q  <= port_d;
            stb_q   <= stb_d;
        end
    end

    assign sda_oe   = oe_q;
    assign busy     = busy_q;
    assign port_out = port_q;
    assign byte_stb = stb_q;

endmodule
